usb_rx_decoder: RTL
===================

Name: usb_rx_decoder

Overview:
USB full-speed receive front end.
- Takes synchronized D+/D- line samples and recovers bit timing from line edges.
- Performs NRZI decoding, bit unstuffing, SYNC detection and EOP detection.
- Feeds crc_16 directly: d_decoded, enable (shift_enable), init (crc_init).
- Reports packet boundaries and line errors to the receive-packet controller.

Parameters:
CLKS_PER_BIT, 4, system clocks per USB bit (48 MHz / 12 Mbps); even value, minimum 4.
STUFF_LIMIT, 6, consecutive decoded 1s after which a stuffed 0 is expected.

Ports:
clk  in  1  system clock, rising edge.
n_rst  in  1  asynchronous active-low reset.
d_plus  in  1  D+ line, already 2-flop synchronized.
d_minus  in  1  D- line, already 2-flop synchronized.
d_decoded  out  1  NRZI-decoded, unstuffed data bit; valid when shift_enable=1.
shift_enable  out  1  1-cycle strobe per payload bit; drives crc_16 enable.
crc_init  out  1  1-cycle pulse on valid SYNC; drives crc_16 init.
eop  out  1  1-cycle pulse on valid end of packet.
rcving  out  1  high from first SYNC bit until return to IDLE.
rcv_error  out  1  sticky error flag; cleared by next crc_init.

Behaviour:
- Reset values: all outputs 0 except d_decoded=1. Internal prev-line=J, FSM=IDLE, timer=0, ones count=0.
- Line states:
  - J = (d_plus=1, d_minus=0); K = (0,1); SE0 = (0,0).
  - SE1 = (1,1) is illegal: set rcv_error and go to ERR.
- Bit timer (sub-module):
  - Free-running count 0..CLKS_PER_BIT-1.
  - Forced to 0 on any d_plus change versus the previous clock.
  - sample strobe fires when count == CLKS_PER_BIT/2.
- NRZI decoding, per strobe: decoded = (d_plus == prev_d_plus), then prev_d_plus <= d_plus. prev_d_plus is reloaded to 1 when entering IDLE.
- FSM, all transitions on sample strobes:
  - IDLE: stay while line=J. Line=K → SYNC, rcving=1, and capture this first bit.
  - SYNC: shift decoded bits into an 8-bit register.
    - After 8 bits == 8'b0000_0001 (time order; KJKJKJKK): pulse crc_init, clear rcv_error → DATA.
    - Otherwise: rcv_error=1 → ERR.
    - SE0 during SYNC: rcv_error=1 → EOP.
  - DATA:
    - Line=SE0 → EOP1.
    - Otherwise run unstuff logic:
      - Decoded 1: increment ones count.
      - Decoded 0: clear ones count.
      - If ones count == STUFF_LIMIT, the current bit is stuffed. A 0 is dropped (no shift_enable) and the count is cleared. A 1 sets rcv_error → ERR.
    - Non-stuffed bits: d_decoded <= bit and shift_enable pulses 1 cycle. Both outputs are registered, so they appear 1 clk after the strobe.
  - EOP1: SE0 → EOP2; otherwise rcv_error=1 → ERR.
  - EOP2: J → pulse eop → IDLE, rcving=0. SE0 stays in EOP2 (tolerates a stretched SE0). K sets rcv_error → ERR.
  - ERR: no shift_enable. SE0 → EOP2 (no eop pulse is issued from an error path); a direct J sample for 8 strobes → IDLE.
- crc_init and shift_enable never assert in the same cycle.
- Only one of eop and rcv_error's rising edge may occur per packet end.
- Reset mid-packet: all state returns to reset values immediately (asynchronous); no eop pulse.
- The timer re-aligns on every edge, so jitter of ±1 clk per bit is tolerated.

Decomposition:
- usb_rx_pkg holds:
  - typedef enum for FSM states (IDLE, SYNC, DATA, EOP1, EOP2, ERR).
  - typedef enum for line state (J, K, SE0, SE1).
  - constant SYNC_PATTERN = 8'b0000_0001.
  - default STUFF_LIMIT.
- Sub-module usb_bit_timer: edge detect plus counter, outputs the sample strobe.

Test Plan:
- Reset: hold n_rst=0 with line J → all outputs at reset values, d_decoded=1. Release and hold J for 20 bits → no strobes out, rcving=0.
- Valid SYNC plus address 8'b11001111 plus CRC16 16'b0000001010100010, then SE0,SE0,J:
  - crc_init pulses once; exactly 24 shift_enable pulses with the matching bit sequence.
  - eop pulses once; rcv_error=0.
  - crc_16 check_16 == 0 afterwards.
- Bit stuffing: payload of 8 decoded 1s (transmitted with a stuffed 0 after the sixth) → exactly 8 shift_enable pulses, all with d_decoded=1; rcv_error=0.
- Stuff error: 7 consecutive decoded 1s with no stuffed 0 → rcv_error=1 on the 7th strobe, no further shift_enable, no eop. SE0,SE0,J then returns to IDLE.
- Bad SYNC: KJKJKJKJ → no crc_init, rcv_error=1, no shift_enable.
- Timing and reset: ±1-clk edge jitter on every bit of a valid packet → same output as the clean case. Assert n_rst=0 mid-DATA → rcving=0 and shift_enable=0 immediately, no eop.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive front end.
package usb_rx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      DATA,
      EOP1,
      EOP2,
      ERR
   } rx_state_t;

   typedef enum logic [1:0] {
      LINE_J,
      LINE_K,
      LINE_SE0,
      LINE_SE1
   } line_state_t;

   localparam logic [7:0] SYNC_PATTERN        = 8'b0000_0001;
   localparam int         DEFAULT_STUFF_LIMIT = 6;
   localparam int         ERR_IDLE_BITS       = 8;

   function automatic line_state_t decode_line(input logic dp, input logic dm);
      line_state_t ls;
      case ({dp, dm})
         2'b10:   ls = LINE_J;
         2'b01:   ls = LINE_K;
         2'b00:   ls = LINE_SE0;
         default: ls = LINE_SE1;
      endcase
      return ls;
   endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// Recovers bit timing: a free-running bit counter re-aligned on every D+ edge,
// producing a one-cycle sample strobe at mid-bit.
module usb_bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic n_rst,
   input  logic d_plus,
   output logic sample
);

   localparam int            CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2);

   logic          prev_dp;
   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         prev_dp <= 1'b1;
         count   <= '0;
      end else begin
         prev_dp <= d_plus;
         if (d_plus != prev_dp)
            count <= '0;
         else if (count == LAST)
            count <= '0;
         else
            count <= count + CW'(1);
      end
   end

   assign sample = (count == MID);

endmodule

// File: rtl/usb_rx_decoder.sv
// USB full-speed receive front end: NRZI decode, bit unstuffing, SYNC and EOP
// detection, feeding a CRC-16 checker and the receive-packet controller.
module usb_rx_decoder
   import usb_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int STUFF_LIMIT  = DEFAULT_STUFF_LIMIT
) (
   input  logic clk,
   input  logic n_rst,
   input  logic d_plus,
   input  logic d_minus,
   output logic d_decoded,
   output logic shift_enable,
   output logic crc_init,
   output logic eop,
   output logic rcving,
   output logic rcv_error
);

   localparam int OW = $clog2(STUFF_LIMIT + 1);

   logic          sample;
   logic          line_dp;
   logic          line_dm;
   logic          prev_nrzi;
   logic          decoded;
   logic [6:0]    sync_sr;
   logic [7:0]    sync_next;
   logic [2:0]    bit_cnt;
   logic [OW-1:0] ones_cnt;
   logic [2:0]    j_cnt;
   line_state_t   line;
   rx_state_t     state;

   usb_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk   (clk),
      .n_rst (n_rst),
      .d_plus(d_plus),
      .sample(sample)
   );

   // The FSM looks at the line one clock late so that a bit shortened by
   // edge jitter is still sampled before the next transition lands.
   assign line      = decode_line(line_dp, line_dm);
   assign decoded   = (line_dp == prev_nrzi);
   assign sync_next = {sync_sr, decoded};

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         line_dp      <= 1'b1;
         line_dm      <= 1'b0;
         prev_nrzi    <= 1'b1;
         state        <= IDLE;
         sync_sr      <= '0;
         bit_cnt      <= '0;
         ones_cnt     <= '0;
         j_cnt        <= '0;
         d_decoded    <= 1'b1;
         shift_enable <= 1'b0;
         crc_init     <= 1'b0;
         eop          <= 1'b0;
         rcving       <= 1'b0;
         rcv_error    <= 1'b0;
      end else begin
         line_dp      <= d_plus;
         line_dm      <= d_minus;
         shift_enable <= 1'b0;
         crc_init     <= 1'b0;
         eop          <= 1'b0;
         if (sample) begin
            prev_nrzi <= line_dp;
            if (line == LINE_SE1) begin
               rcv_error <= 1'b1;
               j_cnt     <= '0;
               state     <= ERR;
            end else begin
               case (state)
                  IDLE: begin
                     if (line == LINE_K) begin
                        sync_sr <= {6'b0, decoded};
                        bit_cnt <= 3'd1;
                        rcving  <= 1'b1;
                        state   <= SYNC;
                     end
                  end
                  SYNC: begin
                     if (line == LINE_SE0) begin
                        rcv_error <= 1'b1;
                        state     <= EOP1;
                     end else begin
                        sync_sr <= sync_next[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                           if (sync_next == SYNC_PATTERN) begin
                              crc_init  <= 1'b1;
                              rcv_error <= 1'b0;
                              ones_cnt  <= '0;
                              state     <= DATA;
                           end else begin
                              rcv_error <= 1'b1;
                              j_cnt     <= '0;
                              state     <= ERR;
                           end
                        end
                     end
                  end
                  DATA: begin
                     // After STUFF_LIMIT ones the transmitter must insert a 0,
                     // which is dropped; a 1 in that slot is a stuffing violation.
                     if (line == LINE_SE0) begin
                        state <= EOP1;
                     end else if (ones_cnt == OW'(STUFF_LIMIT)) begin
                        if (decoded) begin
                           rcv_error <= 1'b1;
                           j_cnt     <= '0;
                           state     <= ERR;
                        end else begin
                           ones_cnt <= '0;
                        end
                     end else begin
                        d_decoded    <= decoded;
                        shift_enable <= 1'b1;
                        ones_cnt     <= decoded ? ones_cnt + OW'(1) : '0;
                     end
                  end
                  EOP1: begin
                     if (line == LINE_SE0) begin
                        state <= EOP2;
                     end else begin
                        rcv_error <= 1'b1;
                        j_cnt     <= '0;
                        state     <= ERR;
                     end
                  end
                  EOP2: begin
                     if (line == LINE_J) begin
                        eop       <= !rcv_error;
                        rcving    <= 1'b0;
                        prev_nrzi <= 1'b1;
                        state     <= IDLE;
                     end else if (line == LINE_K) begin
                        rcv_error <= 1'b1;
                        j_cnt     <= '0;
                        state     <= ERR;
                     end
                  end
                  ERR: begin
                     // Recover on an EOP (reported silently) or a long idle J.
                     if (line == LINE_SE0) begin
                        state <= EOP2;
                     end else if (line == LINE_J) begin
                        if (j_cnt == 3'(ERR_IDLE_BITS - 1)) begin
                           rcving    <= 1'b0;
                           prev_nrzi <= 1'b1;
                           state     <= IDLE;
                        end else begin
                           j_cnt <= j_cnt + 3'd1;
                        end
                     end else begin
                        j_cnt <= '0;
                     end
                  end
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end

endmodule
